// File: rtl/param_icache.sv
// Set-associative instruction cache, true-LRU, multi-word block fill.
// Optional hit/miss statistics under ICACHE_STATS_EN.
module param_icache #(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             iflush,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int IB = $clog2(SETS);
  localparam int TW = 30 - OB - IB;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OW-1:0] KLAST = OW'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  state_t            state;
  logic [WAYS-1:0]   valid [SETS];
  logic [TW-1:0]     tags  [SETS][WAYS];
  ages_t             age   [SETS];
  logic [31:0]       data  [SETS][WAYS][BLOCK_WORDS];

  logic [IB-1:0]     fset;
  logic [AW-1:0]     fway;
  logic [TW-1:0]     ftag;
  logic [OW-1:0]     k;

  logic [IB-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [OW-1:0]     off;
  logic              hit_any;
  logic [AW-1:0]     hit_way;
  logic [AW-1:0]     vic;
  logic              miss_start;
  logic              unused_ok;

  assign idx       = imemaddr[2+OB +: IB];
  assign tag       = imemaddr[31 -: TW];
  assign unused_ok = ^imemaddr[1:0];

  if (OB > 0) begin : g_off
    assign off = imemaddr[2 +: OW];
  end else begin : g_nooff
    assign off = '0;
  end

  function automatic ages_t age_init();
    ages_t r;
    for (int i = 0; i < WAYS; i++)
      r[i] = AW'(i);
    return r;
  endfunction

  // Ways younger than the touched one age by one; touched way becomes MRU.
  function automatic ages_t lru_upd(
    input ages_t a,
    input logic [AW-1:0] w
  );
    ages_t r;
    r = a;
    for (int j = 0; j < WAYS; j++)
      if (a[j] < a[w])
        r[j] = a[j] + AW'(1);
    r[w] = '0;
    return r;
  endfunction

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
  end

  always_comb begin
    vic = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[idx][w] == AW'(WAYS - 1))
        vic = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w])
        vic = AW'(w);
  end

  assign ihit = (state == IDLE) && imemREN
             && !iflush && hit_any;
  assign imemload = ihit ? data[idx][hit_way][off]
                         : 32'h0;
  assign miss_start = (state == IDLE) && imemREN
                   && !iflush && !hit_any;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      iREN  <= 1'b0;
      iaddr <= '0;
      fset  <= '0;
      fway  <= '0;
      ftag  <= '0;
      k     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        age[s]   <= age_init();
      end
    end else if (iflush) begin
      state <= IDLE;
      iREN  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        age[s]   <= age_init();
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (imemREN && hit_any) begin
            age[idx] <= lru_upd(age[idx], hit_way);
          end else if (miss_start) begin
            state <= FILL;
            iREN  <= 1'b1;
            iaddr <= {imemaddr[31:2+OB],
                      {(OB+2){1'b0}}};
            fset  <= idx;
            fway  <= vic;
            ftag  <= tag;
            k     <= '0;
          end
        end
        FILL: begin
          if (!iwait) begin
            if (k == KLAST) begin
              valid[fset][fway] <= 1'b1;
              age[fset] <= lru_upd(age[fset], fway);
              state <= IDLE;
              iREN  <= 1'b0;
            end else begin
              k     <= k + OW'(1);
              iaddr <= iaddr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays need no reset; only valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (state == FILL && !iwait && !iflush) begin
      data[fset][fway][k] <= iload;
      if (k == KLAST)
        tags[fset][fway] <= ftag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && !(&hit_count))
        hit_count <= hit_count + CNT_W'(1);
      if (miss_start && !(&miss_count))
        miss_count <= miss_count + CNT_W'(1);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_param_icache.sv
// Randomized bench for param_icache against a recency-list cache model.
// Default geometry: 2 ways, 8 sets, 2-word blocks.
module tb_param_icache;

  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int BW   = 2;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          imemREN;
  logic [31:0]   imemaddr;
  logic          iflush;
  logic          ihit;
  logic [31:0]   imemload;
  logic          iREN;
  logic [31:0]   iaddr;
  logic          iwait;
  logic [31:0]   iload;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder configuration and log of presented words.
  int          fixed_wait = 0;
  int          wneed = 0;
  int          wcnt = 0;
  logic [31:0] acc_q[$];

  // Reference model: valid/tag per line, recency list per set (MRU first).
  bit          mv  [SETS][WAYS];
  logic [31:0] mt  [SETS][WAYS];
  int          ord [SETS][WAYS];
  int          m_hits;
  int          m_miss;

  param_icache #(
    .WAYS(WAYS), .SETS(SETS),
    .BLOCK_WORDS(BW), .CNT_W(CW)
  ) dut (
    .CLK(clk), .RST(rst),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .iflush(iflush), .ihit(ihit),
    .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hDEAD0000 ^ a;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!iREN) begin
      iwait = 1'b1;
      wcnt  = 0;
      wneed = (fixed_wait >= 0) ? fixed_wait
                                : int'($urandom_range(0, 2));
    end else if (wcnt < wneed) begin
      iwait = 1'b1;
      wcnt++;
    end else begin
      iwait = 1'b0;
      iload = memf(iaddr);
      acc_q.push_back(iaddr);
      wcnt  = 0;
      wneed = (fixed_wait >= 0) ? fixed_wait
                                : int'($urandom_range(0, 2));
    end
  end

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w]  = 1'b0;
        ord[s][w] = w;
      end
  endfunction

  function automatic void m_touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < WAYS; i++)
      if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--)
      ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!mv[s][w]) return w;
    return ord[s][WAYS-1];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imemREN = 1'b0;
    iflush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    iflush = 1'b1;
    @(posedge clk);
    #1 iflush = 1'b0;
    m_clear();
  endtask

  task automatic fetch(
    input  logic [31:0] a,
    output bit          was_hit
  );
    int s, w, v, n;
    bit eh;
    logic [31:0] t;
    s  = int'((a >> 3) % SETS);
    t  = a >> 6;
    eh = 1'b0;
    w  = 0;
    for (int j = 0; j < WAYS; j++)
      if (mv[s][j] && mt[s][j] == t) begin
        eh = 1'b1;
        w  = j;
      end
    @(negedge clk);
    imemaddr = a;
    imemREN  = 1'b1;
    #1;
    check("hit", {31'b0, ihit}, {31'b0, eh});
    was_hit = ihit;
    if (eh) begin
      check("hit_data", imemload, memf(a & ~32'h3));
      m_touch(s, w);
      m_hits++;
    end else begin
      v = m_victim(s);
      m_miss++;
      n = 0;
      while (!ihit && n < 200) begin
        @(negedge clk);
        #1 n++;
      end
      check("fill_done", {31'b0, ihit}, 32'd1);
      if (fixed_wait >= 0)
        check("penalty", n, 1 + BW * (fixed_wait + 1));
      check("fill_data", imemload, memf(a & ~32'h3));
      mv[s][v] = 1'b1;
      mt[s][v] = t;
      m_touch(s, v);
      m_hits++;
    end
    @(posedge clk);
    #1 imemREN = 1'b0;
  endtask

  initial begin
    bit h;
    int n;
    rst = 1'b1;
    imemREN = 1'b0;
    imemaddr = '0;
    iflush = 1'b0;
    iwait = 1'b1;
    iload = '0;
    m_clear();
    m_hits = 0;
    m_miss = 0;
    #12;
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_iren", {31'b0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_load", imemload, 32'd0);
    check("rst_hitc", hit_count, 32'd0);
    check("rst_missc", miss_count, 32'd0);
    do_reset();

    // Cold miss, two wait cycles per word
    fixed_wait = 2;
    acc_q.delete();
    fetch(32'h0, h);
    check("cold_miss", {31'b0, h}, 32'd0);
    check("cold_nacc", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) begin
      check("cold_a0", acc_q[0], 32'h0);
      check("cold_a1", acc_q[1], 32'h4);
    end
    fetch(32'h4, h);
    check("cold_w1_hit", {31'b0, h}, 32'd1);

    // LRU eviction order within set 0
    do_reset();
    fixed_wait = 0;
    fetch(32'h000, h);
    check("lru_a", {31'b0, h}, 32'd0);
    fetch(32'h040, h);
    check("lru_b", {31'b0, h}, 32'd0);
    fetch(32'h000, h);
    check("lru_c", {31'b0, h}, 32'd1);
    fetch(32'h080, h);
    check("lru_d", {31'b0, h}, 32'd0);
    fetch(32'h000, h);
    check("lru_keep", {31'b0, h}, 32'd1);
    fetch(32'h040, h);
    check("lru_evict", {31'b0, h}, 32'd0);

    // Flush overrides a same-cycle hit
    @(negedge clk);
    imemaddr = 32'h040;
    imemREN  = 1'b1;
    iflush   = 1'b1;
    #1 check("flush_ovr", {31'b0, ihit}, 32'd0);
    @(posedge clk);
    #1 begin
      iflush  = 1'b0;
      imemREN = 1'b0;
    end
    m_clear();

    // Flush in the middle of a fill (k=1)
    fetch(32'h000, h);
    fixed_wait = 1;
    @(negedge clk);
    imemaddr = 32'h100;
    imemREN  = 1'b1;
    @(posedge clk);
    #1 imemREN = 1'b0;
    m_miss++;
    n = 0;
    while (!(iREN && iaddr == 32'h104) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("flush_k1", iaddr, 32'h104);
    iflush = 1'b1;
    @(posedge clk);
    #1 check("flush_iren", {31'b0, iREN}, 32'd0);
    iflush = 1'b0;
    m_clear();
    fetch(32'h000, h);
    check("flush_inval", {31'b0, h}, 32'd0);

    // Idle at a cold address
    do_flush();
    @(negedge clk);
    imemaddr = 32'h200;
    imemREN  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_iren", {31'b0, iREN}, 32'd0);
      check("idle_ihit", {31'b0, ihit}, 32'd0);
    end

    // Asynchronous reset between clock edges during a fill
    do_reset();
    fixed_wait = 2;
    @(negedge clk);
    imemaddr = 32'h300;
    imemREN  = 1'b1;
    @(posedge clk);
    #1 imemREN = 1'b0;
    check("fill_started", {31'b0, iREN}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_iren", {31'b0, iREN}, 32'd0);
    check("arst_iaddr", iaddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_hits = 0;
    m_miss = 0;
    fixed_wait = 0;
    fetch(32'h300, h);
    check("arst_inval", {31'b0, h}, 32'd0);

    // Stats: one miss then three hit cycles
    do_reset();
    fetch(32'h000, h);
    fetch(32'h000, h);
    fetch(32'h004, h);
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    check("stat_hit", hit_count, 32'd3);
    check("stat_miss", miss_count, 32'd1);
`else
    check("stat_hit_off", hit_count, 32'd0);
    check("stat_miss_off", miss_count, 32'd0);
`endif

    // Randomized traffic: 4 tags per set to force evictions
    do_reset();
    fixed_wait = -1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0)
        do_flush();
      else if ($urandom_range(0, 7) == 0)
        @(negedge clk);
      fetch($urandom & 32'h0000_00FC, h);
    end
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    check("rnd_hitc", hit_count, m_hits);
    check("rnd_missc", miss_count, m_miss);
`else
    check("rnd_hitc_off", hit_count, 32'd0);
    check("rnd_missc_off", miss_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_icache.md
# param_icache

Parametrised set-associative instruction cache for the pipelined MIPS core: successor to the fixed direct-mapped icache instanced inside the caches block. Serves datapath fetches (imemREN/imemaddr → ihit/imemload) with a zero-cycle combinational hit path. On a miss it fills a multi-word block from the memory controller (iREN/iaddr/iwait/iload). Replacement is true LRU; the block adds a synchronous flush and optional hit/miss statistics.

## Interface
Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4
- SETS, 8, number of sets; power of two, ≥2
- BLOCK_WORDS, 2, 32-bit words per block; power of two, ≥1
- CNT_W, 32, statistics counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- iflush  in  1  invalidate all lines
- ihit  out  1  fetch satisfied this cycle
- imemload  out  32  fetched word; 0 when ihit=0
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, bits [1:0]=0
- iwait  in  1  memory busy; data valid when iREN=1 and iwait=0
- iload  in  32  memory read data
- hit_count  out  CNT_W  hit statistic
- miss_count  out  CNT_W  miss statistic

## Operation
- Address split: word offset = [2 +: log2(BLOCK_WORDS)], index = next log2(SETS) bits, tag = remaining upper bits.
- Per line: valid, tag, BLOCK_WORDS data words. Per set: log2(WAYS)-bit age per way (WAYS=1: no ages).
- FSM states:
  - IDLE: compare tag against all valid ways of the indexed set. Hit: ihit=1, imemload = matching word. imemREN=1 and miss: latch block-aligned address, choose victim, word counter k=0, go to FILL.
  - FILL: iREN=1, iaddr = latched base + 4k. On iwait=0, write iload into victim word k. On the last word, also set valid and tag, update LRU, return to IDLE; otherwise k++.
- Victim selection: lowest-indexed invalid way; otherwise the way with age WAYS-1.
- LRU update on hit or on fill completion of way w with age a: every way with age < a increments; w's age becomes 0.
- Reset ages: way i = i.
- Changes to imemaddr during FILL are ignored; the fill completes for the latched address, and ihit=0 throughout FILL.
- iflush (any state): clear all valid bits, reset ages, abort any fill (iREN drops next cycle), go to IDLE. iflush overrides a same-cycle hit, so ihit=0 that cycle.
- imemREN=0: ihit=0 and no fill starts.

## Timing
- Reset values: state IDLE, all valid=0, iREN=0, iaddr=0, ihit=0, imemload=0, counters 0.
- Hit latency: 0 cycles, combinational from imemaddr in IDLE.
- Miss: 1 cycle to enter FILL, then BLOCK_WORDS memory transactions, then IDLE. ihit rises in the cycle after the final iwait=0. With iwait=0 always, the miss penalty is BLOCK_WORDS+1 cycles.
- iREN and iaddr are registered outputs. iaddr changes only in the cycle after an accepted word.
- Asserting RST mid-fill immediately forces all reset values; the partial block is never marked valid.

## Configuration
- ICACHE_STATS_EN defined: hit_count increments on every cycle with ihit=1. miss_count increments on each IDLE→FILL transition. Both counters saturate at all-ones and clear only on RST.
- ICACHE_STATS_EN undefined: the counter logic is omitted and both ports are tied to 0.

## Test plan
Defaults apply: WAYS=2, SETS=8, BLOCK_WORDS=2, so index = [5:3] and tag = [31:6].
- Cold miss: after reset, fetch 0x00 with memory returning 0xDEAD0000/0xDEAD0004 after 2 wait cycles each. Required: iaddr sequence 0x00 then 0x04; ihit=1 with imemload=0xDEAD0000 the cycle after the second accept; a fetch of 0x04 then hits in 0 cycles.
- LRU: fill 0x000 and 0x040, re-fetch 0x000, then fetch 0x080. Required: 0x080 evicts the 0x040 line; 0x000 still hits; 0x040 misses.
- Flush mid-fill: assert iflush while k=1. Required: iREN=0 next cycle; state IDLE; 0x000 misses afterwards.
- Idle: imemREN=0 for 10 cycles at a cold address. Required: iREN stays 0 and ihit stays 0.
- Async reset mid-fill: assert RST between clock edges. Required: iREN=0 immediately; the line is invalid after reset is released.
- Stats (macro on): 1 miss followed by 3 hit cycles gives hit_count=3, miss_count=1. With the macro off, both ports read 0.
